// File: rtl/dac_stream_interp.sv
// Multi-channel sample FIFO feeding a 2^SAMPLE_RATE upsampler (zero-order hold or linear).
// Primes to a fill threshold, flags underrun/overflow, and re-primes after an underrun.
module dac_stream_interp #(
  parameter int DATAWIDTH   = 14,
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 512,
  parameter int SAMPLE_RATE = 4,
  parameter int START_LEVEL = DEPTH / 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        mode,
  input  logic                        wr_en,
  input  logic [NUM_CH*DATAWIDTH-1:0] wr_data,
  output logic                        wr_ready,
  input  logic                        clr_err,
  output logic [NUM_CH*DATAWIDTH-1:0] dac_data,
  output logic                        dac_valid,
  output logic                        underrun,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      fill_level
);
  localparam int DW    = DATAWIDTH;
  localparam int W     = NUM_CH * DW;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int PW    = (SAMPLE_RATE > 0) ? SAMPLE_RATE : 1;
  localparam int PDW   = DW + PW + 2;
  localparam int RD_AT = (SAMPLE_RATE > 0) ? (1 << SAMPLE_RATE) - 2 : 0;
  localparam logic [PW-1:0] PH_LAST = PW'((1 << SAMPLE_RATE) - 1);
  localparam logic [PW-1:0] PH_RD   = PW'(RD_AT);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] START_C = CW'(START_LEVEL);
  localparam logic [DW-1:0] MID     = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PRIME, LOAD1, LOAD2, RUN} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [W-1:0]  rd_data_reg;
  logic          full, empty, do_wr, rd_en;

  state_t        state_reg, state_next;
  logic [PW-1:0] phase_reg;
  logic          mode_reg, mode_eff;
  logic [W-1:0]  cur_reg, nxt_reg, dac_data_reg, interp_data;
  logic          dac_valid_reg, underrun_reg, overflow_reg;
  logic          underrun_set, wrap, rd_due;

  assign full       = (count_reg == DEPTH_C);
  assign empty      = (count_reg == '0);
  assign do_wr      = wr_en & ~full;
  assign wr_ready   = (count_reg < DEPTH_C);
  assign fill_level = count_reg;
  assign dac_data   = dac_data_reg;
  assign dac_valid  = dac_valid_reg;
  assign underrun   = underrun_reg;
  assign overflow   = overflow_reg;

  // Storage array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
    if (rd_en) rd_data_reg <= mem[rd_ptr_reg];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + CW'(do_wr) - CW'(rd_en);
    end
  end

  // Mode is latched at the start of each interval and held for its remainder.
  assign mode_eff = (phase_reg == '0) ? mode : mode_reg;
  assign rd_due   = (SAMPLE_RATE == 0) || (phase_reg == PH_RD);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DW-1:0]         cur_ch, nxt_ch;
    logic signed [DW:0]    diff;
    logic signed [PDW-1:0] diff_x, ph_x, prod, step;
    assign cur_ch = cur_reg[gi*DW +: DW];
    assign nxt_ch = nxt_reg[gi*DW +: DW];
    assign diff   = $signed({1'b0, nxt_ch}) - $signed({1'b0, cur_ch});
    assign diff_x = PDW'(diff);
    assign ph_x   = $signed(PDW'({1'b0, phase_reg}));
    assign prod   = diff_x * ph_x;
    assign step   = prod >>> SAMPLE_RATE;
    assign interp_data[gi*DW +: DW] = mode_eff ? (cur_ch + step[DW-1:0]) : cur_ch;
  end

  always_comb begin
    state_next   = state_reg;
    rd_en        = 1'b0;
    underrun_set = 1'b0;
    wrap         = 1'b0;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:  state_next = PRIME;
        PRIME: if (count_reg >= START_C) begin
                 rd_en      = 1'b1;
                 state_next = LOAD1;
               end
        LOAD1: begin
                 rd_en      = 1'b1;
                 state_next = LOAD2;
               end
        LOAD2: begin
                 state_next = RUN;
                 // Without upsampling the next pop must already be in flight at the first wrap.
                 if (SAMPLE_RATE == 0) begin
                   if (empty) begin
                     underrun_set = 1'b1;
                     state_next   = PRIME;
                   end else begin
                     rd_en = 1'b1;
                   end
                 end
               end
        RUN:   begin
                 if (rd_due) begin
                   if (empty) begin
                     underrun_set = 1'b1;
                     state_next   = PRIME;
                   end else begin
                     rd_en = 1'b1;
                   end
                 end
                 if (phase_reg == PH_LAST && state_next == RUN) wrap = 1'b1;
               end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      phase_reg     <= '0;
      mode_reg      <= 1'b0;
      cur_reg       <= '0;
      nxt_reg       <= '0;
      dac_data_reg  <= {NUM_CH{MID}};
      dac_valid_reg <= 1'b0;
      underrun_reg  <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == RUN && state_next == RUN)
        phase_reg <= wrap ? '0 : phase_reg + PW'(1);
      else
        phase_reg <= '0;
      if (state_reg == RUN && phase_reg == '0) mode_reg <= mode;
      if (state_reg == LOAD1) cur_reg <= rd_data_reg;
      if (state_reg == LOAD2) nxt_reg <= rd_data_reg;
      if (wrap) begin
        cur_reg <= nxt_reg;
        nxt_reg <= rd_data_reg;
      end
      case (state_reg)
        IDLE: begin
          dac_data_reg  <= {NUM_CH{MID}};
          dac_valid_reg <= 1'b0;
        end
        RUN: begin
          dac_data_reg  <= interp_data;
          dac_valid_reg <= 1'b1;
        end
        default: dac_valid_reg <= 1'b0;
      endcase
      underrun_reg <= underrun_set | (underrun_reg & ~clr_err);
      overflow_reg <= (wr_en & full) | (overflow_reg & ~clr_err);
    end
  end
endmodule

// File: tb/tb_dac_stream_interp.sv
// Directed + randomized bench for dac_stream_interp; output streams are compared against
// an arithmetic model of hold / floor-linear interpolation over the written entries.
module tb_dac_stream_interp;
  localparam int DW = 14, NCH = 2, DEPTH = 16, SR = 2, START = 4, NP = 1 << SR;

  logic                clk = 1'b0;
  logic                rst, enable, mode, wr_en, clr_err;
  logic [NCH*DW-1:0]   wr_data, dac_data;
  logic                wr_ready, dac_valid, underrun, overflow;
  logic [4:0]          fill_level;

  int n_checks = 0;
  int n_fail   = 0;
  int e0 [64];
  int e1 [64];

  dac_stream_interp #(
    .DATAWIDTH(DW), .NUM_CH(NCH), .DEPTH(DEPTH), .SAMPLE_RATE(SR), .START_LEVEL(START)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .wr_en(wr_en), .wr_data(wr_data),
    .wr_ready(wr_ready), .clr_err(clr_err), .dac_data(dac_data), .dac_valid(dac_valid),
    .underrun(underrun), .overflow(overflow), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_checks++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic write_n(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'b1;
      wr_data = {DW'(e1[i]), DW'(e0[i])};
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Output j sits in interval j/NP between entries i and i+1, at fraction (j%NP)/NP.
  function automatic int model_ch(input bit ch, input int j, input bit lin);
    int i, p, c, n, num;
    i = j / NP;
    p = j % NP;
    c = ch ? e1[i] : e0[i];
    n = ch ? e1[i+1] : e0[i+1];
    if (!lin) return c;
    num = (n - c) * p;
    if (num >= 0) return c + num / NP;
    return c - ((-num + NP - 1) / NP);
  endfunction

  task automatic expect_stream(input int k, input bit lin, input bit chk_lat);
    int got, cyc, first;
    logic [NCH*DW-1:0] want;
    got = 0;
    cyc = 0;
    first = -1;
    while (got < k && cyc < k * 3 + 40) begin
      tick();
      cyc++;
      if (dac_valid === 1'b1) begin
        if (first < 0) first = cyc;
        want = {DW'(model_ch(1'b1, got, lin)), DW'(model_ch(1'b0, got, lin))};
        check($sformatf("stream[%0d]", got), 64'(dac_data), 64'(want));
        got++;
      end
    end
    check("stream_count", 64'(got), 64'(k));
    if (chk_lat) check("first_valid_within_5", 64'(first >= 1 && first <= 5), 64'd1);
  endtask

  logic [NCH*DW-1:0] mids, frozen;
  int waited;
  bit lin;

  initial begin
    mids    = {14'd8192, 14'd8192};
    rst     = 1'b1;
    enable  = 1'b0;
    mode    = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    clr_err = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset_dac_data", 64'(dac_data), 64'(mids));
    check("reset_valid", 64'(dac_valid), 64'd0);
    check("reset_underrun", 64'(underrun), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    check("reset_fill", 64'(fill_level), 64'd0);
    check("reset_wr_ready", 64'(wr_ready), 64'd1);

    // Linear ramp on ch0, constant ch1, then run dry.
    for (int i = 0; i < 12; i++) begin
      e0[i] = 100 * (i + 1);
      e1[i] = 50;
    end
    write_n(12);
    check("fill_after_12", 64'(fill_level), 64'd12);
    mode   = 1'b1;
    enable = 1'b1;
    expect_stream(40, 1'b1, 1'b1);

    waited = 0;
    while (underrun !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    check("underrun_set", 64'(underrun), 64'd1);
    tick();
    check("underrun_valid_low", 64'(dac_valid), 64'd0);
    frozen = dac_data;
    repeat (5) tick();
    check("underrun_data_frozen", 64'(dac_data), 64'(frozen));
    check("underrun_still_invalid", 64'(dac_valid), 64'd0);
    check("underrun_fill_zero", 64'(fill_level), 64'd0);

    // Refill while priming; the new stream restarts from the new entries.
    for (int i = 0; i < 8; i++) begin
      e0[i] = int'($urandom_range(0, 16383));
      e1[i] = int'($urandom_range(0, 16383));
    end
    fork
      write_n(8);
      expect_stream(20, 1'b1, 1'b0);
    join
    check("underrun_sticky", 64'(underrun), 64'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("underrun_cleared", 64'(underrun), 64'd0);
    enable = 1'b0;
    tick();

    // Zero-order hold.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      e0[i] = 100 * (i + 1);
      e1[i] = 50;
    end
    write_n(12);
    mode   = 1'b0;
    enable = 1'b1;
    expect_stream(12, 1'b0, 1'b1);
    enable = 1'b0;

    // Falling slope: floor rounding toward the lower code.
    do_reset();
    e0[0] = 10;
    e0[1] = 7;
    for (int i = 0; i < 6; i++) begin
      if (i >= 2) e0[i] = int'($urandom_range(0, 16383));
      e1[i] = int'($urandom_range(0, 16383));
    end
    write_n(6);
    mode   = 1'b1;
    enable = 1'b1;
    expect_stream(8, 1'b1, 1'b1);
    enable = 1'b0;

    // Random entries and random mode.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 10; i++) begin
        e0[i] = int'($urandom_range(0, 16383));
        e1[i] = int'($urandom_range(0, 16383));
      end
      write_n(10);
      lin    = 1'($urandom_range(0, 1));
      mode   = lin;
      enable = 1'b1;
      expect_stream(32, lin, 1'b1);
      enable = 1'b0;
    end

    // Overflow: DEPTH+3 writes with the engine idle.
    do_reset();
    for (int i = 0; i < DEPTH + 3; i++) begin
      e0[i] = int'($urandom_range(0, 16383));
      e1[i] = int'($urandom_range(0, 16383));
    end
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i == DEPTH - 1) check("wr_ready_before_full", 64'(wr_ready), 64'd1);
      if (i == DEPTH) begin
        check("wr_ready_at_full", 64'(wr_ready), 64'd0);
        check("no_overflow_yet", 64'(overflow), 64'd0);
      end
      wr_en   = 1'b1;
      wr_data = {DW'(e1[i]), DW'(e0[i])};
      tick();
    end
    wr_en = 1'b0;
    check("overflow_set", 64'(overflow), 64'd1);
    check("fill_full", 64'(fill_level), 64'(DEPTH));
    check("wr_ready_full", 64'(wr_ready), 64'd0);
    wr_en   = 1'b1;
    clr_err = 1'b1;
    tick();
    check("overflow_set_wins", 64'(overflow), 64'd1);
    wr_en = 1'b0;
    tick();
    clr_err = 1'b0;
    check("overflow_cleared", 64'(overflow), 64'd0);
    check("fill_after_drops", 64'(fill_level), 64'(DEPTH));
    mode   = 1'b1;
    enable = 1'b1;
    expect_stream(12, 1'b1, 1'b1);

    // Overfill while running, then reset mid-RUN.
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = '0;
      tick();
    end
    wr_en = 1'b0;
    check("overflow_in_run", 64'(overflow), 64'd1);
    check("valid_before_rst", 64'(dac_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_dac_data", 64'(dac_data), 64'(mids));
    check("rst_valid", 64'(dac_valid), 64'd0);
    check("rst_fill", 64'(fill_level), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    enable = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
